// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE -> RD -> (WR) -> RSP with byte/half/word lanes.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned IdxW = ADDR_W - 2;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

  state_e            state_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic              busy_q;
  logic              ack_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IdxW-1:0] idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic            size_bad;
  logic            range_bad;
  logic            misalign;
  logic            acc_err;

  assign idx     = addr_q[ADDR_W-1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = mem[idx];

  // Stores only exist as B/H/W; the unsigned encodings are load-only.
  assign size_bad  = (size_q == 3'b011) || (size_q[2:1] == 2'b11) || (we_q && size_q[2]);
  assign range_bad = 32'(idx) >= DEPTH_WORDS;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((size_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = size_bad || range_bad || misalign;

  function automatic logic [31:0] load_ext(logic [31:0] w, logic [2:0] sz, logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d, logic [1:0] sz,
                                        logic [1:0] ln);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00:   m[{ln, 3'b000} +: 8] = d[7:0];
      2'b01:   m[{ln[1], 4'b0000} +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            state_q <= StRd;
          end
        end
        StRd: begin
          buf_q <= rd_word;
          if (acc_err) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            ack_q   <= 1'b1;
            state_q <= StRsp;
          end else if (we_q) begin
            state_q <= StWr;
          end else begin
            err_q   <= 1'b0;
            rdata_q <= load_ext(rd_word, size_q, lane);
            ack_q   <= 1'b1;
            state_q <= StRsp;
          end
        end
        StWr: begin
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
          ack_q   <= 1'b1;
          state_q <= StRsp;
        end
        StRsp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == StWr) begin
      mem[idx] <= merge(buf_q, wdata_q, size_q[1:0], lane);
    end
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, random and directed accesses.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 48;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [2:0]    size = 3'b000;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = 32'h0;
  logic          busy;
  logic          ack;
  logic [31:0]   rdata;
  logic          err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .we   (we),
    .size (size),
    .addr (addr),
    .wdata(wdata),
    .busy (busy),
    .ack  (ack),
    .rdata(rdata),
    .err  (err)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rd;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mb[DEPTH*4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && ack) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_err"}, {31'h0, err}, {31'h0, mon_e.err});
        if (mon_e.chk_rd) check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Reference model over a byte array: returns error flag and load value, applies stores.
  task automatic model(input bit w, input logic [2:0] sz, input int a, input logic [31:0] d,
                       output logic e, output logic [31:0] rd, output bit chk);
    int nbytes;
    int base;
    logic [31:0] r;
    e = 1'b0;
    r = 32'h0;
    chk = 1'b1;
    if (sz == 3 || sz == 6 || sz == 7 || (w && sz >= 4)) e = 1'b1;
    if ((a / 4) >= int'(DEPTH)) e = 1'b1;
    nbytes = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((a % nbytes) != 0) e = 1'b1;
`endif
    base = a - (a % nbytes);
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nbytes; i++) mb[base+i] = d[8*i +: 8];
        chk = 1'b0;
      end else begin
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = mb[base+i];
        if (!sz[2] && nbytes < 4 && r[8*nbytes-1]) begin
          for (int i = nbytes; i < 4; i++) r[8*i +: 8] = 8'hFF;
        end
      end
    end
    rd = r;
  endtask

  task automatic do_access(input string name, input bit w, input logic [2:0] sz, input int a,
                           input logic [31:0] d, input bit use_k, input logic k_err,
                           input logic [31:0] k_rd);
    int   n;
    logic e;
    logic [31:0] rd;
    bit   chk;
    exp_t x;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait: got busy=1 expected busy=0 within 20 cycles", name);
      return;
    end
    model(w, sz, a, d, e, rd, chk);
    x.err    = use_k ? k_err : e;
    x.rdata  = use_k ? k_rd : rd;
    x.chk_rd = use_k ? 1'b1 : chk;
    x.due    = cyc + ((w && !e) ? 3 : 2);
    x.name   = name;
    sb.push_back(x);
    we = w;
    size = sz;
    addr = AW'(a);
    wdata = d;
    req = 1'b1;
    @(negedge clk);
    #1;
    req = 1'b0;
    we = 1'($urandom);
    size = 3'($urandom);
    addr = AW'($urandom);
    wdata = $urandom;
    check({name, "_busy"}, {31'h0, busy}, 32'h1);
    // Pulse req while busy; it must be dropped, not queued.
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      if (busy && $urandom_range(0, 1) == 1) req = 1'b1;
      @(negedge clk);
      #1;
      req = 1'b0;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 10 cycles", name);
      sb.delete();
    end
  endtask

  initial begin
    int a;
    logic [2:0] sz;
    bit w;
    #2 reset = 1'b0;
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < int'(DEPTH); i++) do_access("fill", 1'b1, 3'b010, i * 4, $urandom, 0, 0, 0);

    do_access("sw_10", 1'b1, 3'b010, 'h10, 32'hDEADBEEF, 0, 0, 0);
    do_access("lw_10_a", 1'b0, 3'b010, 'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF);
    do_access("sb_11", 1'b1, 3'b000, 'h11, 32'h000000AA, 0, 0, 0);
    do_access("lw_10_b", 1'b0, 3'b010, 'h10, 32'h0, 1, 1'b0, 32'hDEADAAEF);
    do_access("lb_11", 1'b0, 3'b000, 'h11, 32'h0, 1, 1'b0, 32'hFFFFFFAA);
    do_access("lbu_11", 1'b0, 3'b100, 'h11, 32'h0, 1, 1'b0, 32'h000000AA);
    do_access("sh_12", 1'b1, 3'b001, 'h12, 32'h00008001, 0, 0, 0);
    do_access("lw_10_c", 1'b0, 3'b010, 'h10, 32'h0, 1, 1'b0, 32'h8001AAEF);
    do_access("lh_12", 1'b0, 3'b001, 'h12, 32'h0, 1, 1'b0, 32'hFFFF8001);
    do_access("lhu_12", 1'b0, 3'b101, 'h12, 32'h0, 1, 1'b0, 32'h00008001);
`ifdef DMEM_MISALIGN_CHECK_EN
    do_access("lw_13", 1'b0, 3'b010, 'h13, 32'h0, 1, 1'b1, 32'h0);
`else
    do_access("lw_13", 1'b0, 3'b010, 'h13, 32'h0, 1, 1'b0, 32'h8001AAEF);
`endif
    do_access("ld_size011", 1'b0, 3'b011, 'h10, 32'h0, 1, 1'b1, 32'h0);
    do_access("st_size100", 1'b1, 3'b100, 'h10, 32'h11111111, 0, 0, 0);
    do_access("lw_10_d", 1'b0, 3'b010, 'h10, 32'h0, 1, 1'b0, 32'h8001AAEF);
    do_access("lw_oob", 1'b0, 3'b010, 'hC0, 32'h0, 1, 1'b1, 32'h0);
    do_access("sw_oob", 1'b1, 3'b010, 'hC4, 32'h55555555, 0, 0, 0);

    // Store aborted by reset while in RD: no ack, no write.
    we = 1'b1;
    size = 3'b010;
    addr = 8'h20;
    wdata = 32'h12345678;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_ack", {31'h0, ack}, 32'h0);
    check("abort_err", {31'h0, err}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    do_access("lw_20_after_abort", 1'b0, 3'b010, 'h20, 32'h0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    sz = 3'b000;
        2, 3:    sz = 3'b001;
        4, 5:    sz = 3'b010;
        6:       sz = 3'b100;
        7:       sz = 3'b101;
        default: sz = 3'($urandom);
      endcase
      a = int'($urandom_range(0, 255));
      do_access("rand", w, sz, a, $urandom, 0, 0, 0);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
